fpdp_div_arbiter: RTL and testbench

FPDP_DIV_ARBITER -- requirements
Module: fpdp_div_arbiter

---
 rtl/fpdp_div_arbiter.sv | 123 ++++++++++++
 tb/tb_fpdp_div_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpdp_div_arbiter.sv
// Round-robin arbiter that shares one double-precision divider among N_REQ
// requesters. One transaction is in flight at a time, and a WAIT timeout
// returns a quiet NaN with rsp_err set. All outputs are registered, so the
// pulse that belongs to a state is visible in the cycle after the decision.
module fpdp_div_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rset,
  input  logic [N_REQ-1:0]     req,
  input  logic [64*N_REQ-1:0]  req_dividend,
  input  logic [64*N_REQ-1:0]  req_divisor,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [63:0]          rsp_quotient,
  output logic                 rsp_err,
  output logic [63:0]          div_dividend,
  output logic [63:0]          div_divisor,
  output logic                 div_start,
  input  logic                 div_done,
  input  logic [63:0]          div_quotient,
  output logic                 busy
);

  localparam int          IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [7:0]  TERM = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [7:0]       wait_cnt;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [63:0]      win_dividend;
  logic [63:0]      win_divisor;

  // Pick the first requester at or above rr_ptr (wrapping) and fetch its operands
  always_comb begin
    int               idx;
    logic [N_REQ-1:0] req_sh;
    win_found    = 1'b0;
    win_id       = '0;
    win_dividend = '0;
    win_divisor  = '0;
    idx          = 0;
    req_sh       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx    = (int'(rr_ptr) + k) % N_REQ;
      req_sh = req >> idx;
      if (!win_found && req_sh[0]) begin
        win_found    = 1'b1;
        win_id       = IDW'(idx);
        win_dividend = 64'(req_dividend >> (64 * idx));
        win_divisor  = 64'(req_divisor >> (64 * idx));
      end
    end
  end

  // Transaction FSM: grant, start the divider, wait for done or timeout, respond
  always_ff @(posedge clk) begin
    if (rset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      wait_cnt     <= '0;
      gnt          <= '0;
      rsp_valid    <= '0;
      rsp_err      <= 1'b0;
      div_start    <= 1'b0;
      rsp_quotient <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt          <= N_REQ'(1) << win_id;
            cur_id       <= win_id;
            div_dividend <= win_dividend;
            div_divisor  <= win_divisor;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          div_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            rsp_valid    <= N_REQ'(1) << cur_id;
            rsp_quotient <= div_quotient;
            rsp_err      <= 1'b0;
            state        <= RESP;
          end else if (wait_cnt == TERM) begin
            rsp_valid    <= N_REQ'(1) << cur_id;
            rsp_quotient <= QNAN;
            rsp_err      <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          rr_ptr <= (cur_id == IDW'(N_REQ - 1)) ? '0 : cur_id + IDW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fpdp_div_arbiter.sv
// Directed self-checking bench for fpdp_div_arbiter (N_REQ=4, TIMEOUT_CYC=255).
module tb_fpdp_div_arbiter;

  logic         clk = 1'b0;
  logic         rset;
  logic [3:0]   req;
  logic [255:0] req_dividend;
  logic [255:0] req_divisor;
  logic [3:0]   gnt;
  logic [3:0]   rsp_valid;
  logic [63:0]  rsp_quotient;
  logic         rsp_err;
  logic [63:0]  div_dividend;
  logic [63:0]  div_divisor;
  logic         div_start;
  logic         div_done;
  logic [63:0]  div_quotient;
  logic         busy;

  logic [63:0]  dvd [4];
  logic [63:0]  dvs [4];

  int           n_cmp = 0;
  int           n_err = 0;
  bit           mon_en = 1'b0;

  assign req_dividend = {dvd[3], dvd[2], dvd[1], dvd[0]};
  assign req_divisor  = {dvs[3], dvs[2], dvs[1], dvs[0]};

  fpdp_div_arbiter #(.N_REQ(4), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rset(rset), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
    .rsp_err(rsp_err), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_start(div_start), .div_done(div_done), .div_quotient(div_quotient),
    .busy(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // gnt, rsp_valid and div_start must never overlap
  always @(negedge clk) begin
    if (mon_en)
      checkOutput("pulse_exclusive",
                  64'(int'(|gnt) + int'(|rsp_valid) + int'(div_start) <= 1), 64'd1);
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic run_txn(input string tag, input int exp_id, input logic [3:0] req_after,
                         input int lat, input logic [63:0] q);
    logic [63:0] oh;
    oh = 64'd1 << exp_id;
    for (int w = 0; w < 20; w++) begin
      tick();
      if (gnt != 4'b0) break;
    end
    checkOutput({tag, "_gnt"}, 64'(gnt), oh);
    checkOutput({tag, "_dividend"}, div_dividend, dvd[exp_id]);
    checkOutput({tag, "_divisor"}, div_divisor, dvs[exp_id]);
    applyStimulus(req_after);
    tick();
    checkOutput({tag, "_start"}, 64'(div_start), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    repeat (lat) tick();
    div_done     = 1'b1;
    div_quotient = q;
    tick();
    div_done     = 1'b0;
    div_quotient = 64'hDEAD_BEEF_DEAD_BEEF;
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), oh);
    checkOutput({tag, "_quot"}, rsp_quotient, q);
    checkOutput({tag, "_err"}, 64'(rsp_err), 64'd0);
    tick();
    checkOutput({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rset         = 1'b1;
    req          = 4'b1111;
    div_done     = 1'b0;
    div_quotient = '0;
    for (int i = 0; i < 4; i++) begin
      dvd[i] = 64'h4000_0000_0000_0000 + 64'(i) * 64'h0010_0000_0000_0000;
      dvs[i] = 64'h3FF0_0000_0000_0000 + 64'(i + 1);
    end

    // Reset, with requests held to show reset wins
    tick();
    tick();
    checkOutput("rst_gnt", 64'(gnt), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_start", 64'(div_start), 64'd0);
    checkOutput("rst_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_quot", rsp_quotient, 64'd0);
    checkOutput("rst_dividend", div_dividend, 64'd0);
    checkOutput("rst_divisor", div_divisor, 64'd0);
    mon_en = 1'b1;

    // Single request 1.0 / 2.0 with a 10-cycle divider
    $display("[TB] single request");
    dvd[0] = 64'h3FF0_0000_0000_0000;
    dvs[0] = 64'h4000_0000_0000_0000;
    rset = 1'b0;
    applyStimulus(4'b0001);
    run_txn("single", 0, 4'b0000, 10, 64'h3FE0_0000_0000_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("single_no_regrant", 64'(gnt), 64'd0);
    end
    dvd[0] = 64'h4000_0000_0000_0000;
    dvs[0] = 64'h3FF0_0000_0000_0001;

    // All four requesting continuously from a fresh pointer
    $display("[TB] round robin");
    rset = 1'b1;
    tick();
    rset = 1'b0;
    applyStimulus(4'b1111);
    for (int k = 0; k < 8; k++)
      run_txn($sformatf("rr%0d", k), k % 4, 4'b1111, 2, 64'hC0DE_0000_0000_0000 + 64'(k));
    applyStimulus(4'b0000);

    // Serve id 2, then 0101 must wrap to id 0
    $display("[TB] wrap");
    applyStimulus(4'b0100);
    run_txn("wrap_a", 2, 4'b0000, 1, 64'h4008_0000_0000_0000);
    applyStimulus(4'b0101);
    run_txn("wrap_b", 0, 4'b0000, 1, 64'h4010_0000_0000_0000);

    // Divider never answers: qNaN with error after 255 WAIT cycles
    $display("[TB] timeout");
    applyStimulus(4'b0010);
    tick();
    checkOutput("to_gnt", 64'(gnt), 64'd2);
    applyStimulus(4'b0000);
    tick();
    checkOutput("to_start", 64'(div_start), 64'd1);
    repeat (254) tick();
    checkOutput("to_early", 64'(rsp_valid), 64'd0);
    tick();
    checkOutput("to_rsp_valid", 64'(rsp_valid), 64'd2);
    checkOutput("to_quot", rsp_quotient, 64'h7FF8_0000_0000_0000);
    checkOutput("to_err", 64'(rsp_err), 64'd1);
    tick();
    checkOutput("to_idle", 64'(busy), 64'd0);
    applyStimulus(4'b0100);
    run_txn("after_to", 2, 4'b0000, 3, 64'h3FD0_0000_0000_0000);

    // Reset during WAIT abandons the transaction; late done is ignored
    $display("[TB] reset mid-flight");
    applyStimulus(4'b1000);
    tick();
    checkOutput("mid_gnt", 64'(gnt), 64'd8);
    applyStimulus(4'b0000);
    tick();
    checkOutput("mid_start", 64'(div_start), 64'd1);
    repeat (3) tick();
    rset = 1'b1;
    tick();
    rset = 1'b0;
    checkOutput("mid_busy", 64'(busy), 64'd0);
    checkOutput("mid_rsp", 64'(rsp_valid), 64'd0);
    div_done     = 1'b1;
    div_quotient = 64'h1234_5678_9ABC_DEF0;
    tick();
    div_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mid_late_rsp", 64'(rsp_valid), 64'd0);
      checkOutput("mid_late_busy", 64'(busy), 64'd0);
    end
    applyStimulus(4'b1111);
    run_txn("mid_ptr0", 0, 4'b0000, 1, 64'h4020_0000_0000_0000);

    // Done arrives on the terminal-count cycle: done wins
    $display("[TB] done at terminal count");
    applyStimulus(4'b0010);
    tick();
    checkOutput("tc_gnt", 64'(gnt), 64'd2);
    applyStimulus(4'b0000);
    tick();
    checkOutput("tc_start", 64'(div_start), 64'd1);
    repeat (254) tick();
    checkOutput("tc_early", 64'(rsp_valid), 64'd0);
    div_done     = 1'b1;
    div_quotient = 64'h3FF8_0000_0000_0000;
    tick();
    div_done = 1'b0;
    checkOutput("tc_rsp_valid", 64'(rsp_valid), 64'd2);
    checkOutput("tc_quot", rsp_quotient, 64'h3FF8_0000_0000_0000);
    checkOutput("tc_err", 64'(rsp_err), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
